// File: rtl/movavg_inv.sv
// Inverse of a 4-tap moving-sum filter: recovers x[n] from y[n] = x[n]+x[n-1]+x[n-2]+x[n-3].
// Single-entry output register with valid/ready handshake on both sides.
module movavg_inv #(
    parameter int WL = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [WL-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [WL-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [15:0]   sample_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [WL-1:0] dout_q, dout_d;
    logic [WL-1:0] yprev_q, yprev_d;
    logic [WL-1:0] xh1_q, xh1_d;
    logic [WL-1:0] xh2_q, xh2_d;
    logic [WL-1:0] xh3_q, xh3_d;
    logic [WL-1:0] xh4_q, xh4_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          accept;
    logic          out_xfer;
    logic [WL-1:0] x_n;

    assign dout_valid = (state_q == FULL);
    assign din_ready  = !clr && (!dout_valid || dout_ready);
    assign accept     = din_valid && din_ready;
    assign out_xfer   = dout_valid && dout_ready;
    assign dout       = dout_q;
    assign sample_cnt = cnt_q;

    // y[n] - y[n-1] = x[n] - x[n-4]; all terms wrap modulo 2^WL.
    assign x_n = din - yprev_q + xh4_q;

    // NOTE: every next-state signal is given its hold value before any branch,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        yprev_d = yprev_q;
        xh1_d   = xh1_q;
        xh2_d   = xh2_q;
        xh3_d   = xh3_q;
        xh4_d   = xh4_q;
        cnt_d   = cnt_q;

        if (clr) begin
            state_d = EMPTY;
            yprev_d = '0;
            xh1_d   = '0;
            xh2_d   = '0;
            xh3_d   = '0;
            xh4_d   = '0;
            cnt_d   = '0;
        end else begin
            if (out_xfer) begin
                cnt_d = cnt_q + 16'd1;
            end

            unique case (state_q)
                EMPTY: begin
                    if (accept) state_d = FULL;
                end
                FULL: begin
                    if (out_xfer && !accept) state_d = EMPTY;
                end
                default: state_d = EMPTY;
            endcase

            // Filter history advances only on an accepted sample.
            if (accept) begin
                dout_d  = x_n;
                yprev_d = din;
                xh1_d   = x_n;
                xh2_d   = xh1_q;
                xh3_d   = xh2_q;
                xh4_d   = xh3_q;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            dout_q  <= '0;
            yprev_q <= '0;
            xh1_q   <= '0;
            xh2_q   <= '0;
            xh3_q   <= '0;
            xh4_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            yprev_q <= yprev_d;
            xh1_q   <= xh1_d;
            xh2_q   <= xh2_d;
            xh3_q   <= xh3_d;
            xh4_q   <= xh4_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_movavg_inv.sv
// Directed self-checking bench for movavg_inv: reset, decode, wrap, backpressure,
// bubbles, clear and asynchronous reset scenarios with hand-computed expectations.
module tb_movavg_inv;

    localparam int WL = 64;

    logic          clk;
    logic          reset;
    logic          clr;
    logic [WL-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [WL-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [15:0]   sample_cnt;

    int total = 0;
    int bad   = 0;

    movavg_inv #(.WL(WL)) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        clr        = 1'b0;
        din_valid  = 1'b0;
        din        = '0;
        dout_ready = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        clr        = 1'b0;
        din_valid  = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        #3;
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b expected 0", dout_valid);
        end
        total++;
        if (dout !== '0) begin
            bad++; $display("FAIL reset_dout: got %h expected 0", dout);
        end
        total++;
        if (sample_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_cnt: got %0d expected 0", sample_cnt);
        end
        total++;
        if (din_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b expected 1", din_ready);
        end
        step();
        reset = 1'b0;
        #1;
        total++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0",
                            din_ready, dout_valid);
        end
    endtask

    task automatic test_basic();
        logic [WL-1:0] ys [5];
        logic [WL-1:0] xs [5];
        ys = '{64'd1, 64'd3, 64'd6, 64'd10, 64'd14};
        xs = '{64'd1, 64'd2, 64'd3, 64'd4,  64'd5};
        apply_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din_valid = 1'b1;
            din       = ys[i];
            step();
            total++;
            if (dout_valid !== 1'b1 || dout !== xs[i]) begin
                bad++; $display("FAIL basic_dout[%0d]: got valid=%b %0d expected valid=1 %0d",
                                i, dout_valid, dout, xs[i]);
            end
        end
        din_valid = 1'b0;
        step();
        total++;
        if (dout_valid !== 1'b0 || sample_cnt !== 16'd5) begin
            bad++; $display("FAIL basic_cnt: got valid=%b cnt=%0d expected valid=0 cnt=5",
                            dout_valid, sample_cnt);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        dout_ready = 1'b1;
        din_valid  = 1'b1;
        din        = 64'd1;
        step();
        total++;
        if (dout !== 64'd1) begin
            bad++; $display("FAIL wrap_first: got %h expected 1", dout);
        end
        din = 64'd0;
        step();
        total++;
        if (dout_valid !== 1'b1 || dout !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++; $display("FAIL wrap_second: got %h expected ffffffffffffffff", dout);
        end
        din_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        apply_reset();
        dout_ready = 1'b1;
        din_valid  = 1'b1;
        din        = 64'd1;
        step();
        dout_ready = 1'b0;
        din        = 64'd3;
        #1;
        total++;
        if (din_ready !== 1'b0) begin
            bad++; $display("FAIL bp_ready_low: got %b expected 0", din_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (dout_valid !== 1'b1 || dout !== 64'd1 || din_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d]: got valid=%b dout=%0d ready=%b expected 1 1 0",
                                i, dout_valid, dout, din_ready);
            end
        end
        dout_ready = 1'b1;
        #1;
        total++;
        if (din_ready !== 1'b1) begin
            bad++; $display("FAIL bp_ready_high: got %b expected 1", din_ready);
        end
        step();
        total++;
        if (dout !== 64'd2) begin
            bad++; $display("FAIL bp_retry: got %0d expected 2", dout);
        end
        din = 64'd6;
        step();
        total++;
        if (dout !== 64'd3) begin
            bad++; $display("FAIL bp_third: got %0d expected 3", dout);
        end
        din_valid = 1'b0;
        step();
        total++;
        if (dout_valid !== 1'b0 || sample_cnt !== 16'd3) begin
            bad++; $display("FAIL bp_cnt: got valid=%b cnt=%0d expected valid=0 cnt=3",
                            dout_valid, sample_cnt);
        end
    endtask

    task automatic test_bubbles();
        logic [WL-1:0] ys [3];
        logic [WL-1:0] xs [3];
        ys = '{64'd1, 64'd3, 64'd6};
        xs = '{64'd1, 64'd2, 64'd3};
        apply_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1;
            din       = ys[i];
            step();
            total++;
            if (dout_valid !== 1'b1 || dout !== xs[i]) begin
                bad++; $display("FAIL bubble_dout[%0d]: got valid=%b %0d expected valid=1 %0d",
                                i, dout_valid, dout, xs[i]);
            end
            din_valid = 1'b0;
            din       = 64'hDEAD;
            step();
            step();
            total++;
            if (dout_valid !== 1'b0) begin
                bad++; $display("FAIL bubble_idle[%0d]: got valid=%b expected 0", i, dout_valid);
            end
        end
        total++;
        if (sample_cnt !== 16'd3) begin
            bad++; $display("FAIL bubble_cnt: got %0d expected 3", sample_cnt);
        end
    endtask

    task automatic test_clear();
        logic [WL-1:0] ys [3];
        ys = '{64'd1, 64'd3, 64'd6};
        apply_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1;
            din       = ys[i];
            step();
        end
        total++;
        if (dout !== 64'd3) begin
            bad++; $display("FAIL clr_pre: got %0d expected 3", dout);
        end
        clr = 1'b1;
        din = 64'd99;
        #1;
        total++;
        if (din_ready !== 1'b0) begin
            bad++; $display("FAIL clr_ready: got %b expected 0", din_ready);
        end
        step();
        clr = 1'b0;
        total++;
        if (dout_valid !== 1'b0 || sample_cnt !== 16'd0) begin
            bad++; $display("FAIL clr_state: got valid=%b cnt=%0d expected valid=0 cnt=0",
                            dout_valid, sample_cnt);
        end
        din = 64'd5;
        step();
        total++;
        if (dout !== 64'd5) begin
            bad++; $display("FAIL clr_first: got %0d expected 5", dout);
        end
        din = 64'd12;
        step();
        total++;
        if (dout !== 64'd7) begin
            bad++; $display("FAIL clr_second: got %0d expected 7", dout);
        end
        din_valid = 1'b0;
        step();
        total++;
        if (sample_cnt !== 16'd2) begin
            bad++; $display("FAIL clr_cnt: got %0d expected 2", sample_cnt);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        dout_ready = 1'b1;
        din_valid  = 1'b1;
        din        = 64'd1;
        step();
        din = 64'd3;
        step();
        din_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (dout_valid !== 1'b0 || dout !== '0 || sample_cnt !== 16'd0) begin
            bad++; $display("FAIL async_reset: got valid=%b dout=%0d cnt=%0d expected 0 0 0",
                            dout_valid, dout, sample_cnt);
        end
        din_valid = 1'b1;
        din       = 64'd77;
        step();
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL async_no_accept: got valid=%b expected 0", dout_valid);
        end
        reset = 1'b0;
        din   = 64'd10;
        step();
        total++;
        if (dout_valid !== 1'b1 || dout !== 64'd10) begin
            bad++; $display("FAIL async_restart: got valid=%b %0d expected valid=1 10",
                            dout_valid, dout);
        end
        din_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_bubbles();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
